// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the byte-serial instruction fetch
// Rev 1.0
// ============================================================================
package fetch_pkg;

   localparam int unsigned BYTES_PER_INSTR  = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_CHECK_EN
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;
`else
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1
   } fetch_state_t;
`endif

   // 33-bit sum so the last-byte address of an instruction cannot wrap past the limit
   function automatic logic fetch_addr_bad(input logic [31:0] pc, input int unsigned mem_bytes);
      logic [32:0] last_byte;
      last_byte = {1'b0, pc} + 33'd3;
      return (pc[1:0] != 2'b00) || (last_byte >= {1'b0, mem_bytes});
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
// fetch_controller_if : redirect, instruction-memory and decode handshake bundle
// Rev 1.0
// ============================================================================
interface fetch_controller_if;

   logic        Redirect;
   logic [31:0] RedirectPC;
   logic [31:0] MemAddr;
   logic        MemRdEn;
   logic [7:0]  MemData;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] InstructionCode;
   logic [31:0] InstrPC;
   logic        Fault;

   modport master (
      input  Redirect, RedirectPC, MemData, InstrReady,
      output MemAddr, MemRdEn, InstrValid, InstructionCode, InstrPC, Fault
   );

   modport slave (
      output Redirect, RedirectPC, MemData, InstrReady,
      input  MemAddr, MemRdEn, InstrValid, InstructionCode, InstrPC, Fault
   );

endinterface
`default_nettype wire

// File: rtl/fetch_byte_assembler.sv
`default_nettype none
// ============================================================================
// fetch_byte_assembler : byte counter and little-endian 4-lane word register
// Rev 1.0
// ============================================================================
module fetch_byte_assembler
   import fetch_pkg::*;
(
   input  wire logic        Clk,
   input  wire logic        Reset,
   input  wire logic        load_en,
   input  wire logic        clear,
   input  wire logic [7:0]  MemData,
   output logic      [31:0] word,
   output logic             last,
   output logic      [1:0]  byte_cnt
);

   logic [1:0]  r_cnt;
   logic [31:0] r_lanes;
   logic [31:0] w_word;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cnt   <= 2'd0;
         r_lanes <= 32'd0;
      end else if (clear) begin
         r_cnt   <= 2'd0;
         r_lanes <= 32'd0;
      end else if (load_en) begin
         r_lanes[r_cnt*8 +: 8] <= MemData;
         r_cnt                 <= r_cnt + 2'd1;
      end
   end

   // The current byte is merged in so the final lane is available on the edge that completes the word
   always_comb begin
      w_word                = r_lanes;
      w_word[r_cnt*8 +: 8]  = MemData;
   end

   assign word     = w_word;
   assign last     = (r_cnt == 2'(BYTES_PER_INSTR - 1));
   assign byte_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller : byte-serial instruction fetch with valid/ready hand-off;
// optional address check enabled by FETCH_CHECK_EN.  Rev 1.0
// ============================================================================
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned MEM_BYTES = 64
)(
   input  wire logic           Clk,
   input  wire logic           Reset,
   fetch_controller_if.master  bus
);

   fetch_state_t r_state;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  r_code;
   logic [31:0]  r_pc;
   logic         r_valid;

   logic [31:0]  w_word;
   logic         w_last;
   logic [1:0]   w_cnt;
   logic         w_load;
   logic         w_clear;
   logic         w_fault_now;

   if (MEM_BYTES < BYTES_PER_INSTR) begin : g_cfg_check
      $error("fetch_controller: MEM_BYTES must hold at least one instruction");
   end

`ifdef FETCH_CHECK_EN
   logic r_fault;

   assign w_fault_now = (r_state == FETCH) && (w_cnt == 2'd0) &&
                        fetch_addr_bad(r_fetch_pc, MEM_BYTES);
   assign bus.Fault   = r_fault;
`else
   assign w_fault_now = 1'b0;
   assign bus.Fault   = 1'b0;
`endif

   assign w_load  = (r_state == FETCH) && !bus.Redirect && !w_fault_now;
   assign w_clear = bus.Redirect || w_fault_now;

   fetch_byte_assembler u_asm (
      .Clk      (Clk),
      .Reset    (Reset),
      .load_en  (w_load),
      .clear    (w_clear),
      .MemData  (bus.MemData),
      .word     (w_word),
      .last     (w_last),
      .byte_cnt (w_cnt)
   );

   assign bus.MemAddr         = r_fetch_pc + {30'd0, w_cnt};
   assign bus.MemRdEn         = (r_state == FETCH);
   assign bus.InstrValid      = r_valid;
   assign bus.InstructionCode = r_code;
   assign bus.InstrPC         = r_pc;

   // Redirect outranks both the handshake and a pending fault
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= FETCH;
         r_fetch_pc <= RESET_PC;
         r_valid    <= 1'b0;
         r_code     <= 32'd0;
         r_pc       <= RESET_PC;
`ifdef FETCH_CHECK_EN
         r_fault    <= 1'b0;
`endif
      end else if (bus.Redirect) begin
         r_state    <= FETCH;
         r_fetch_pc <= bus.RedirectPC;
         r_valid    <= 1'b0;
`ifdef FETCH_CHECK_EN
         r_fault    <= 1'b0;
`endif
      end else begin
         case (r_state)
            FETCH: begin
`ifdef FETCH_CHECK_EN
               if (w_fault_now) begin
                  r_state <= FAULT;
                  r_fault <= 1'b1;
                  r_valid <= 1'b0;
               end else
`endif
               if (w_last) begin
                  r_code  <= w_word;
                  r_pc    <= r_fetch_pc;
                  r_valid <= 1'b1;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (r_valid && bus.InstrReady) begin
                  r_fetch_pc <= r_fetch_pc + 32'(BYTES_PER_INSTR);
                  r_valid    <= 1'b0;
                  r_state    <= FETCH;
               end
            end
`ifdef FETCH_CHECK_EN
            FAULT: begin
               r_valid <= 1'b0;
            end
`endif
            default: begin
               r_state <= FETCH;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// tb_fetch_controller : directed scoreboard bench for fetch_controller
// Rev 1.0
// ============================================================================
module tb_fetch_controller;
   import fetch_pkg::*;

   localparam int unsigned C_MEM_BYTES = 64;

   typedef struct {
      logic [31:0] code;
      logic [31:0] pc;
   } exp_t;

   logic        Clk;
   logic        Reset;
   logic [7:0]  mem [0:255];
   exp_t        sb_q[$];
   int          checks;
   int          errors;

   fetch_controller_if bus ();

   fetch_controller #(
      .RESET_PC  (32'h0000_0000),
      .MEM_BYTES (C_MEM_BYTES)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   assign bus.MemData = mem[bus.MemAddr[7:0]];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [31:0] word_at(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] code, input logic [31:0] pc);
      exp_t e;
      e.code = code;
      e.pc   = pc;
      sb_q.push_back(e);
   endtask

   // Counts rising edges until InstrValid is seen, then compares against the scoreboard head
   task automatic wait_valid(input int exp_edges, input string tag);
      int   n;
      logic seen;
      exp_t e;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge Clk);
         n++;
         @(negedge Clk);
         seen = bus.InstrValid;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_edges));
      if (sb_q.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, " code"}, bus.InstructionCode, e.code);
         chk({tag, " pc"},   bus.InstrPC,         e.pc);
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      Reset          = 1'b0;
      bus.Redirect   = 1'b0;
      bus.RedirectPC = 32'd0;
      bus.InstrReady = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      {mem[3],  mem[2],  mem[1],  mem[0]}  = 32'h0002_a303;
      {mem[7],  mem[6],  mem[5],  mem[4]}  = 32'h0010_0513;
      {mem[11], mem[10], mem[9],  mem[8]}  = 32'h0020_0593;
      {mem[15], mem[14], mem[13], mem[12]} = 32'h00b5_06b3;
      {mem[19], mem[18], mem[17], mem[16]} = 32'h0000_0013;
      {mem[35], mem[34], mem[33], mem[32]} = 32'h0062_a423;
      {mem[255], mem[254], mem[253], mem[252]} = 32'h0000_006f;

      repeat (2) @(negedge Clk);
      chk("reset valid",   {31'd0, bus.InstrValid}, 32'd0);
      chk("reset code",    bus.InstructionCode,     32'd0);
      chk("reset pc",      bus.InstrPC,             32'd0);
      chk("reset addr",    bus.MemAddr,             32'd0);
      chk("reset rden",    {31'd0, bus.MemRdEn},    32'd1);
      chk("reset fault",   {31'd0, bus.Fault},      32'd0);

      // First two instructions straight out of reset
      Reset          = 1'b1;
      bus.InstrReady = 1'b1;
      push_exp(32'h0002_a303, 32'h0);
      push_exp(32'h0010_0513, 32'h4);
      wait_valid(4, "first");
      wait_valid(5, "second");

      // Backpressure in HOLD
      bus.InstrReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("hold valid", {31'd0, bus.InstrValid}, 32'd1);
         chk("hold code",  bus.InstructionCode,     32'h0010_0513);
         chk("hold pc",    bus.InstrPC,             32'h4);
         chk("hold rden",  {31'd0, bus.MemRdEn},    32'd0);
         chk("hold addr",  bus.MemAddr,             32'h4);
      end
      bus.InstrReady = 1'b1;
      push_exp(word_at(8), 32'h8);
      wait_valid(5, "after hold");

      // Redirect mid-word at byte count 2
      repeat (3) @(negedge Clk);
      chk("mid addr", bus.MemAddr, 32'hE);
      bus.Redirect   = 1'b1;
      bus.RedirectPC = 32'h20;
      @(negedge Clk);
      bus.Redirect   = 1'b0;
      chk("redir valid", {31'd0, bus.InstrValid}, 32'd0);
      chk("redir addr",  bus.MemAddr,             32'h20);
      push_exp(32'h0062_a423, 32'h20);
      wait_valid(4, "redirect");

      // Handshake and redirect together
      bus.Redirect   = 1'b1;
      bus.RedirectPC = 32'h8;
      @(negedge Clk);
      bus.Redirect   = 1'b0;
      chk("hs+redir valid", {31'd0, bus.InstrValid}, 32'd0);
      chk("hs+redir addr",  bus.MemAddr,             32'h8);
      push_exp(word_at(8), 32'h8);
      wait_valid(4, "hs+redir");
      chk("hs+redir sb", 32'(sb_q.size()), 32'd0);

      // Redirect held for several edges
      bus.Redirect   = 1'b1;
      bus.RedirectPC = 32'h4;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         chk("held redir valid", {31'd0, bus.InstrValid}, 32'd0);
         chk("held redir addr",  bus.MemAddr,             32'h4);
      end
      bus.Redirect = 1'b0;
      push_exp(32'h0010_0513, 32'h4);
      wait_valid(4, "held redir");

`ifndef FETCH_CHECK_EN
      // Address wrap from the top of the 32-bit space
      bus.Redirect   = 1'b1;
      bus.RedirectPC = 32'hFFFF_FFFC;
      @(negedge Clk);
      bus.Redirect   = 1'b0;
      push_exp(32'h0000_006f, 32'hFFFF_FFFC);
      push_exp(32'h0002_a303, 32'h0);
      wait_valid(4, "wrap top");
      wait_valid(5, "wrap zero");
      chk("wrap fault", {31'd0, bus.Fault}, 32'd0);
`else
      // Misaligned and out-of-range redirects fault until a good redirect
      for (int k = 0; k < 2; k++) begin
         bus.Redirect   = 1'b1;
         bus.RedirectPC = (k == 0) ? 32'h22 : 32'(C_MEM_BYTES - 2);
         @(negedge Clk);
         bus.Redirect   = 1'b0;
         repeat (3) @(negedge Clk);
         chk("fault flag",  {31'd0, bus.Fault},      32'd1);
         chk("fault rden",  {31'd0, bus.MemRdEn},    32'd0);
         chk("fault valid", {31'd0, bus.InstrValid}, 32'd0);
         bus.Redirect   = 1'b1;
         bus.RedirectPC = 32'h0;
         @(negedge Clk);
         bus.Redirect   = 1'b0;
         chk("fault clear", {31'd0, bus.Fault}, 32'd0);
         push_exp(32'h0002_a303, 32'h0);
         wait_valid(4, "fault recover");
      end
`endif

      // Asynchronous reset in the middle of a fetch
      bus.Redirect   = 1'b1;
      bus.RedirectPC = 32'h10;
      @(negedge Clk);
      bus.Redirect   = 1'b0;
      @(negedge Clk);
      chk("pre-reset addr", bus.MemAddr, 32'h11);
      #2;
      Reset = 1'b0;
      #1;
      chk("async valid", {31'd0, bus.InstrValid}, 32'd0);
      chk("async code",  bus.InstructionCode,     32'd0);
      chk("async pc",    bus.InstrPC,             32'd0);
      chk("async addr",  bus.MemAddr,             32'd0);
      chk("async rden",  {31'd0, bus.MemRdEn},    32'd1);
      @(negedge Clk);
      Reset = 1'b1;
      push_exp(32'h0002_a303, 32'h0);
      wait_valid(4, "post reset");
      chk("final sb", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
